reg_chain_sequencer: RTL and testbench
======================================

REG_CHAIN_SEQUENCER -- requirements
Module: reg_chain_sequencer

Interface
REQ-001 The block SHALL have parameter STEP_GAP, default 10, meaning the number of clock edges between successive chain writes (legal range 1..255).
REQ-002 The block SHALL have parameter TICK_PERIOD, default 7, meaning the number of clock edges between periodic increment requests on x (legal range 2..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: a request to run one load chain, sampled only in IDLE.
REQ-006 The block SHALL have port init, input, 32 bits: the value loaded into x by the chain.
REQ-007 The block SHALL have port tick_en, input, 1 bit: enables the periodic tick counter.
REQ-008 The block SHALL have ports x, y and z, output, 32 bits each: the registered datapath values.
REQ-009 The block SHALL have port busy, output, 1 bit: high while the chain is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-011 The block SHALL have port tick_ack, output, 1 bit: a one-cycle pulse in the cycle after a tick increments x.

Function
REQ-012 The FSM SHALL have the states IDLE, GAP_X, GAP_Y, GAP_Z and DONE, and SHALL use one gap counter, 8 bits wide.
REQ-013 In IDLE, start=1 at an edge (edge S) SHALL move the FSM to GAP_X and clear the gap counter; start in any other state SHALL be ignored.
REQ-014 In each GAP state, the gap counter SHALL increment every edge; the edge on which the counter reaches STEP_GAP-1 is that state's write edge, and on it the counter SHALL clear.
REQ-015 The write edges SHALL fall at S+STEP_GAP, S+2*STEP_GAP and S+3*STEP_GAP.
REQ-016 GAP_X write edge: x <= init; the FSM SHALL go to GAP_Y.
REQ-017 GAP_Y write edge: y <= x+1, where x is the pre-edge value; the FSM SHALL go to GAP_Z.
REQ-018 GAP_Z write edge: z <= y+1, where y is the pre-edge value; the FSM SHALL go to DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 busy SHALL be 1 in the GAP states and 0 in IDLE and DONE.
REQ-021 All additions SHALL be 32-bit modulo 2^32, so 32'hFFFFFFFF + 1 = 0, with no carry output.
REQ-022 The tick counter SHALL count 0..TICK_PERIOD-1 on each edge while tick_en=1, hold while tick_en=0, and wrap to 0.
REQ-023 A tick event SHALL occur on an edge where tick_en=1 and the counter equals TICK_PERIOD-1.
REQ-024 On a tick edge with no chain write to x, x SHALL be set to x+1 and tick_ack SHALL be 1 in the following cycle.
REQ-025 If a tick coincides with the GAP_X write edge, the sequencer SHALL win (x <= init), the tick SHALL be held in a pending flag, and on the next edge x SHALL be set to x+1 with tick_ack pulsed after that edge.
REQ-026 A pending tick SHALL be applied even if tick_en has since dropped, and the pending flag SHALL hold at most one tick.
REQ-027 A tick on the GAP_Y or GAP_Z write edge SHALL be applied in the same edge; y and z SHALL use the pre-edge values.

Reset
REQ-028 Asserting reset SHALL immediately set x=y=z=0, busy=0, done=0, tick_ack=0, FSM=IDLE, both counters=0 and the pending flag clear, including mid-chain.
REQ-029 An aborted chain SHALL NOT resume after reset; the first start after reset release SHALL begin a fresh chain.

Verification
REQ-030 Defaults, tick_en=0, init=5, start at edge 0: the bench SHALL see x=5 after edge 10, y=6 after edge 20, z=7 after edge 30, done=1 for one cycle after edge 30, and busy=0 afterwards.
REQ-031 Defaults, tick_en=1 from reset, start at edge 0 with counters aligned: the bench SHALL see x=1 @7, x=5 @10, x=6 @14, y=7 @20, x=7 @21, x=8 @28, z=8 @30.
REQ-032 STEP_GAP=7, TICK_PERIOD=7, init=100, tick_en=1: the bench SHALL see x=100 @7, x=101 @8 via the deferred tick, and tick_ack high only in the cycle after edge 8.
REQ-033 With x=32'hFFFFFFFF in IDLE and a tick, x SHALL become 0; with y=32'hFFFFFFFF, the GAP_Z write SHALL give z=0.
REQ-034 Reset asserted asynchronously mid-GAP_Y SHALL make all outputs 0 at once; after release, start with init=9 SHALL produce x=9, y=10, z=11 at the normal offsets.
REQ-035 A start pulse during a GAP state or DONE SHALL leave the x/y/z write schedule unchanged and start no second chain.

Source files
------------

// File: rtl/reg_chain_sequencer_if.sv
// Handshake and datapath bundle for reg_chain_sequencer.
// The master drives the chain request and tick enable; the slave returns the registered values.
interface reg_chain_sequencer_if;
   logic        start;
   logic [31:0] init;
   logic        tick_en;
   logic [31:0] x;
   logic [31:0] y;
   logic [31:0] z;
   logic        busy;
   logic        done;
   logic        tick_ack;

   modport master (
      output start, init, tick_en,
      input  x, y, z, busy, done, tick_ack
   );

   modport slave (
      input  start, init, tick_en,
      output x, y, z, busy, done, tick_ack
   );
endinterface

// File: rtl/reg_chain_sequencer.sv
// Three-step register chain (x <= init, y <= x+1, z <= y+1) spaced STEP_GAP edges apart.
// A free-running tick counter also increments x.
module reg_chain_sequencer #(
   parameter int unsigned STEP_GAP    = 10,
   parameter int unsigned TICK_PERIOD = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   reg_chain_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, GAP_X, GAP_Y, GAP_Z, DONE} state_t;

   localparam logic [7:0] GAP_LAST  = 8'(STEP_GAP - 1);
   localparam logic [7:0] TICK_LAST = 8'(TICK_PERIOD - 1);

   state_t      state_q, state_d;
   logic [7:0]  gap_q, gap_d;
   logic [7:0]  tick_cnt_q;
   logic        pending_q;
   logic        tick_ack_q;
   logic [31:0] x_q, y_q, z_q;
   logic        write_x, write_y, write_z;
   logic        tick, x_inc;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      write_x = 1'b0;
      write_y = 1'b0;
      write_z = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = GAP_X;
               gap_d   = 8'd0;
            end
         end
         GAP_X, GAP_Y, GAP_Z: begin
            if (gap_q == GAP_LAST) begin
               gap_d = 8'd0;
               case (state_q)
                  GAP_X:   begin write_x = 1'b1; state_d = GAP_Y; end
                  GAP_Y:   begin write_y = 1'b1; state_d = GAP_Z; end
                  default: begin write_z = 1'b1; state_d = DONE;  end
               endcase
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The chain write to x wins over a tick; the lost tick is replayed one edge later.
   assign tick  = bus.tick_en && (tick_cnt_q == TICK_LAST);
   assign x_inc = (tick && !write_x) || pending_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         gap_q      <= 8'd0;
         tick_cnt_q <= 8'd0;
         pending_q  <= 1'b0;
         tick_ack_q <= 1'b0;
         x_q        <= 32'd0;
         y_q        <= 32'd0;
         z_q        <= 32'd0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         if (bus.tick_en)
            tick_cnt_q <= (tick_cnt_q == TICK_LAST) ? 8'd0 : tick_cnt_q + 8'd1;
         pending_q  <= tick && write_x;
         tick_ack_q <= x_inc;
         if (write_x)
            x_q <= bus.init;
         else if (x_inc)
            x_q <= x_q + 32'd1;
         if (write_y)
            y_q <= x_q + 32'd1;
         if (write_z)
            z_q <= y_q + 32'd1;
      end
   end

   assign bus.x        = x_q;
   assign bus.y        = y_q;
   assign bus.z        = z_q;
   assign bus.busy     = (state_q == GAP_X) || (state_q == GAP_Y) || (state_q == GAP_Z);
   assign bus.done     = (state_q == DONE);
   assign bus.tick_ack = tick_ack_q;

endmodule

// File: tb/tb_reg_chain_sequencer.sv
// Directed bench for reg_chain_sequencer: default instance plus a STEP_GAP=7 instance.
// Edge 0 is the edge that samples start; "after edge k" means #1 past that rising edge.
module tb_reg_chain_sequencer;

   logic clk = 1'b0;
   logic reset;
   int   n_pass  = 0;
   int   n_total = 0;
   int   cur     = 0;

   reg_chain_sequencer_if bus_a ();
   reg_chain_sequencer_if bus_b ();

   reg_chain_sequencer dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   reg_chain_sequencer #(.STEP_GAP(7), .TICK_PERIOD(7)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic at_edge(input int k);
      if (k > cur) begin
         repeat (k - cur) @(posedge clk);
         #1;
         cur = k;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Raises start for one sampling edge on the selected bus; that edge becomes edge 0.
   task automatic start_a(input logic [31:0] value);
      bus_a.init  = value;
      bus_a.start = 1'b1;
      @(posedge clk);
      #1;
      bus_a.start = 1'b0;
      cur = 0;
   endtask

   task automatic start_b(input logic [31:0] value);
      bus_b.init  = value;
      bus_b.start = 1'b1;
      @(posedge clk);
      #1;
      bus_b.start = 1'b0;
      cur = 0;
   endtask

   initial begin
      reset         = 1'b1;
      bus_a.start   = 1'b0;
      bus_a.init    = 32'd0;
      bus_a.tick_en = 1'b0;
      bus_b.start   = 1'b0;
      bus_b.init    = 32'd0;
      bus_b.tick_en = 1'b0;
      #12;
      check("rst_x", bus_a.x, 32'd0);
      check("rst_y", bus_a.y, 32'd0);
      check("rst_z", bus_a.z, 32'd0);
      check("rst_busy", {31'd0, bus_a.busy}, 32'd0);
      check("rst_done", {31'd0, bus_a.done}, 32'd0);
      check("rst_ack", {31'd0, bus_a.tick_ack}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Plain chain, no ticks, init=5.
      start_a(32'd5);
      check("c1_busy0", {31'd0, bus_a.busy}, 32'd1);
      at_edge(9);
      check("c1_x_e9", bus_a.x, 32'd0);
      at_edge(10);
      check("c1_x_e10", bus_a.x, 32'd5);
      at_edge(19);
      check("c1_y_e19", bus_a.y, 32'd0);
      at_edge(20);
      check("c1_y_e20", bus_a.y, 32'd6);
      at_edge(29);
      check("c1_done_e29", {31'd0, bus_a.done}, 32'd0);
      at_edge(30);
      check("c1_z_e30", bus_a.z, 32'd7);
      check("c1_done_e30", {31'd0, bus_a.done}, 32'd1);
      check("c1_busy_e30", {31'd0, bus_a.busy}, 32'd0);
      at_edge(31);
      check("c1_done_e31", {31'd0, bus_a.done}, 32'd0);
      check("c1_busy_e31", {31'd0, bus_a.busy}, 32'd0);

      // Chain with ticks every 7 edges; tick counter first counts on edge 1.
      do_reset();
      start_a(32'd5);
      bus_a.tick_en = 1'b1;
      at_edge(6);
      check("c2_x_e6", bus_a.x, 32'd0);
      at_edge(7);
      check("c2_x_e7", bus_a.x, 32'd1);
      check("c2_ack_e7", {31'd0, bus_a.tick_ack}, 32'd1);
      at_edge(8);
      check("c2_ack_e8", {31'd0, bus_a.tick_ack}, 32'd0);
      at_edge(10);
      check("c2_x_e10", bus_a.x, 32'd5);
      at_edge(14);
      check("c2_x_e14", bus_a.x, 32'd6);
      at_edge(20);
      check("c2_y_e20", bus_a.y, 32'd7);
      at_edge(21);
      check("c2_x_e21", bus_a.x, 32'd7);
      at_edge(28);
      check("c2_x_e28", bus_a.x, 32'd8);
      at_edge(30);
      check("c2_z_e30", bus_a.z, 32'd8);
      bus_a.tick_en = 1'b0;

      // Tick collides with the x write on edge 7; tick_en drops but the deferred tick still lands.
      do_reset();
      start_b(32'd100);
      bus_b.tick_en = 1'b1;
      at_edge(6);
      check("c3_x_e6", bus_b.x, 32'd0);
      at_edge(7);
      bus_b.tick_en = 1'b0;
      check("c3_x_e7", bus_b.x, 32'd100);
      check("c3_ack_e7", {31'd0, bus_b.tick_ack}, 32'd0);
      at_edge(8);
      check("c3_x_e8", bus_b.x, 32'd101);
      check("c3_ack_e8", {31'd0, bus_b.tick_ack}, 32'd1);
      at_edge(9);
      check("c3_ack_e9", {31'd0, bus_b.tick_ack}, 32'd0);
      check("c3_x_e9", bus_b.x, 32'd101);
      at_edge(14);
      check("c3_y_e14", bus_b.y, 32'd102);
      at_edge(21);
      check("c3_z_e21", bus_b.z, 32'd103);
      check("c3_done_e21", {31'd0, bus_b.done}, 32'd1);

      // 32-bit wrap of y+1 and of a tick on x.
      do_reset();
      start_a(32'hFFFF_FFFE);
      at_edge(10);
      check("c4_x_e10", bus_a.x, 32'hFFFF_FFFE);
      at_edge(20);
      check("c4_y_e20", bus_a.y, 32'hFFFF_FFFF);
      at_edge(30);
      check("c4_z_wrap", bus_a.z, 32'd0);
      at_edge(32);
      start_a(32'hFFFF_FFFF);
      at_edge(10);
      check("c4b_x_e10", bus_a.x, 32'hFFFF_FFFF);
      at_edge(20);
      check("c4b_y_wrap", bus_a.y, 32'd0);
      at_edge(32);
      bus_a.tick_en = 1'b1;
      at_edge(38);
      check("c4b_x_pretick", bus_a.x, 32'hFFFF_FFFF);
      at_edge(39);
      check("c4b_x_tickwrap", bus_a.x, 32'd0);
      check("c4b_ack", {31'd0, bus_a.tick_ack}, 32'd1);
      bus_a.tick_en = 1'b0;

      // Asynchronous reset mid GAP_Y, then a fresh chain with stray start pulses.
      do_reset();
      start_a(32'd3);
      at_edge(15);
      check("c5_x_e15", bus_a.x, 32'd3);
      #2;
      reset = 1'b1;
      #1;
      check("c5_async_x", bus_a.x, 32'd0);
      check("c5_async_busy", {31'd0, bus_a.busy}, 32'd0);
      check("c5_async_done", {31'd0, bus_a.done}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("c5_no_resume", {31'd0, bus_a.busy}, 32'd0);
      start_a(32'd9);
      at_edge(10);
      check("c5_x_e10", bus_a.x, 32'd9);
      at_edge(14);
      bus_a.start = 1'b1;
      at_edge(15);
      bus_a.start = 1'b0;
      at_edge(20);
      check("c5_y_e20", bus_a.y, 32'd10);
      at_edge(30);
      check("c5_z_e30", bus_a.z, 32'd11);
      check("c5_done_e30", {31'd0, bus_a.done}, 32'd1);
      bus_a.start = 1'b1;
      at_edge(31);
      bus_a.start = 1'b0;
      check("c5_busy_e31", {31'd0, bus_a.busy}, 32'd0);
      at_edge(33);
      check("c5_busy_e33", {31'd0, bus_a.busy}, 32'd0);
      check("c5_x_e33", bus_a.x, 32'd9);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
